// File: rtl/mux_nto1_scan_pkg.sv
// Shared types and helpers for the N-channel registered scan multiplexer family.
package mux_pkg;

  typedef enum logic {
    MODE_MANUAL = 1'b0,
    MODE_SCAN   = 1'b1
  } mode_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  // Index width for an n-entry selector; never narrower than one bit.
  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mux_nto1_scan_rr_arbiter.sv
// Combinational rotate-priority arbiter: grants the first requester above ptr, wrapping.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter  int N  = 16,
  localparam int SW = sel_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic          grant_vld,
  output logic [SW-1:0] grant_idx
);

  int idx;

  // ptr itself is searched last, so a lone requester at ptr is still granted.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int i = 1; i <= N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!grant_vld && req[idx]) begin
        grant_vld = 1'b1;
        grant_idx = SW'(idx);
      end
    end
  end

endmodule

// File: rtl/mux_nto1_scan.sv
// N-channel W-bit registered mux with manual select or round-robin scan over a mask.
// Handshake: a beat transfers on any edge where valid and ready are both 1; in_ready is
// one-hot (or zero) and only asserted when the output register can load this cycle.
module mux_nto1_scan
  import mux_pkg::*;
#(
  parameter  int N_CH   = 16,
  parameter  int DATA_W = 8,
  localparam int SEL_W  = sel_w(N_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_CH*DATA_W-1:0]   in_data,
  input  logic [N_CH-1:0]          in_valid,
  output logic [N_CH-1:0]          in_ready,
  input  logic                     mode,
  input  logic [SEL_W-1:0]         sel,
  input  logic [N_CH-1:0]          ch_mask,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_sel,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     dbg_state
);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [SEL_W-1:0]    osel_q, osel_d;
  logic [SEL_W-1:0]    ptr_q, ptr_d;

  logic                scan_vld, man_vld, grant_vld, load, capture, is_scan;
  logic [SEL_W-1:0]    scan_idx, grant_idx;
  logic [DATA_W-1:0]   sel_data;

  rr_arbiter #(.N(N_CH)) u_arb (
    .req       (in_valid & ch_mask),
    .ptr       (ptr_q),
    .grant_vld (scan_vld),
    .grant_idx (scan_idx)
  );

  // Out-of-range sel matches no channel, so it simply yields no grant.
  always_comb begin
    man_vld = 1'b0;
    for (int c = 0; c < N_CH; c++) begin
      if (sel == SEL_W'(c)) man_vld = in_valid[c];
    end
  end

  assign is_scan   = (mode_e'(mode) == MODE_SCAN);
  assign grant_vld = is_scan ? scan_vld : man_vld;
  assign grant_idx = is_scan ? scan_idx : sel;
  assign out_valid = (state_q == ST_FULL);
  assign load      = !out_valid || out_ready;
  assign capture   = load && grant_vld;

  always_comb begin
    sel_data = '0;
    in_ready = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (grant_idx == SEL_W'(c)) begin
        sel_data    = in_data[c*DATA_W +: DATA_W];
        in_ready[c] = capture;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    osel_d  = osel_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_EMPTY: if (capture) state_d = ST_FULL;
      ST_FULL:  if (!capture && out_ready) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
    if (capture) begin
      data_d = sel_data;
      osel_d = grant_idx;
      if (is_scan) ptr_d = grant_idx;
    end
  end

  // ptr resets to the last channel so the first scan search begins at channel 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
      osel_q  <= '0;
      ptr_q   <= SEL_W'(N_CH - 1);
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      osel_q  <= osel_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_data  = data_q;
  assign out_sel   = osel_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mux_nto1_scan.sv
// Directed bench for mux_nto1_scan: 16-channel instance plus a 5-channel instance.
module tb_mux_nto1_scan;

  logic         clk = 1'b0;
  logic         rst_n;
  int           checks   = 0;
  int           failures = 0;

  // 16-channel instance
  logic [127:0] a_data;
  logic [15:0]  a_valid, a_ready, a_mask;
  logic         a_mode, a_oready, a_ovalid, a_dbg;
  logic [3:0]   a_sel, a_osel;
  logic [7:0]   a_odata;

  // 5-channel instance
  logic [39:0]  b_data;
  logic [4:0]   b_valid, b_ready, b_mask;
  logic         b_mode, b_oready, b_ovalid, b_dbg;
  logic [2:0]   b_sel, b_osel;
  logic [7:0]   b_odata;

  always #5 clk = ~clk;

  mux_nto1_scan #(.N_CH(16), .DATA_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_data(a_data), .in_valid(a_valid), .in_ready(a_ready),
    .mode(a_mode), .sel(a_sel), .ch_mask(a_mask), .out_data(a_odata), .out_sel(a_osel),
    .out_valid(a_ovalid), .out_ready(a_oready), .dbg_state(a_dbg)
  );

  mux_nto1_scan #(.N_CH(5), .DATA_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_data(b_data), .in_valid(b_valid), .in_ready(b_ready),
    .mode(b_mode), .sel(b_sel), .ch_mask(b_mask), .out_data(b_odata), .out_sel(b_osel),
    .out_valid(b_ovalid), .out_ready(b_oready), .dbg_state(b_dbg)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expect a registered beat from 16-ch channel ch.
  task automatic chk_beat_a(input string tag, input int ch);
    chk({tag, "_valid"}, 32'(a_ovalid), 32'd1);
    chk({tag, "_sel"},   32'(a_osel),   32'(ch));
    chk({tag, "_data"},  32'(a_odata),  32'(8'hA0 + ch));
  endtask

  initial begin
    logic [3:0] exp_seq [4];
    exp_seq = '{4'd0, 4'd15, 4'd0, 4'd15};

    rst_n    = 1'b0;
    a_mode   = 1'b0; a_sel = '0; a_mask = '0; a_valid = '0; a_oready = 1'b0;
    b_mode   = 1'b0; b_sel = '0; b_mask = '0; b_valid = '0; b_oready = 1'b0;
    for (int c = 0; c < 16; c++) a_data[c*8 +: 8] = 8'hA0 + 8'(c);
    for (int c = 0; c < 5; c++)  b_data[c*8 +: 8] = 8'h50 + 8'(c);

    // Reset state
    #12;
    chk("rst_out_valid", 32'(a_ovalid), 32'd0);
    chk("rst_out_data",  32'(a_odata),  32'd0);
    chk("rst_out_sel",   32'(a_osel),   32'd0);
    chk("rst_in_ready",  32'(a_ready),  32'd0);
    chk("rst_dbg_state", 32'(a_dbg),    32'd0);
    rst_n = 1'b1;
    tick();

    // Manual select of channel 5
    a_mode = 1'b0; a_sel = 4'd5; a_valid = 16'h0020; a_oready = 1'b1;
    #1;
    chk("man_in_ready", 32'(a_ready), 32'h0020);
    tick();
    chk_beat_a("man_beat", 5);
    chk("man_dbg_full", 32'(a_dbg), 32'd1);
    a_valid = '0;
    #1;
    chk("man_idle_ready", 32'(a_ready), 32'd0);
    tick();
    chk("man_drain_valid", 32'(a_ovalid), 32'd0);
    chk("man_hold_data",   32'(a_odata),  32'hA5);

    // Full-mask scan: manual use left ptr at its reset value, so scan starts at 0
    a_mode = 1'b1; a_mask = 16'hFFFF; a_valid = 16'hFFFF;
    for (int i = 0; i < 18; i++) begin
      #1;
      chk($sformatf("scan_ready_%0d", i), 32'(a_ready), 32'(16'h1 << (i % 16)));
      tick();
      chk_beat_a($sformatf("scan_beat_%0d", i), i % 16);
    end

    // Reset while a beat is registered drops it without a clock edge
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(a_ovalid), 32'd0);
    chk("arst_out_sel",   32'(a_osel),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Sparse mask after reset: 0,15,0,15, middle channels never ready
    a_mask = 16'h8001;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("mask_ready_%0d", i), 32'(a_ready), 32'(16'h1 << exp_seq[i]));
      tick();
      chk_beat_a($sformatf("mask_beat_%0d", i), int'(exp_seq[i]));
    end

    // Empty mask: no grant, beat drains, ptr stays at 15 so the next grant is 0
    a_mask = '0;
    #1;
    chk("zmask_ready", 32'(a_ready), 32'd0);
    tick();
    chk("zmask_valid", 32'(a_ovalid), 32'd0);
    a_mask = 16'hFFFF;
    tick();
    chk_beat_a("zmask_resume", 0);

    // Backpressure: beat from channel 3 held for 4 stalled cycles
    a_mode = 1'b0; a_sel = 4'd3; a_valid = 16'h0008;
    tick();
    chk_beat_a("bp_load", 3);
    a_oready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin
        a_sel = 4'd6; a_valid = 16'h0040; a_mode = 1'b1;
      end
      #1;
      chk($sformatf("bp_ready_%0d", i), 32'(a_ready), 32'd0);
      tick();
      chk_beat_a($sformatf("bp_hold_%0d", i), 3);
    end
    a_mode = 1'b0;
    a_oready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(a_ready), 32'h0040);
    tick();
    chk_beat_a("bp_b2b", 6);

    // 5-channel instance: out-of-range select never grants
    b_mode = 1'b0; b_sel = 3'd7; b_valid = 5'h1F; b_oready = 1'b1;
    #1;
    chk("n5_oor_ready", 32'(b_ready), 32'd0);
    tick();
    tick();
    chk("n5_oor_valid", 32'(b_ovalid), 32'd0);
    b_sel = 3'd4;
    #1;
    chk("n5_sel4_ready", 32'(b_ready), 32'h10);
    tick();
    chk("n5_sel4_valid", 32'(b_ovalid), 32'd1);
    chk("n5_sel4_sel",   32'(b_osel),   32'd4);
    chk("n5_sel4_data",  32'(b_odata),  32'h54);

    // 5-channel scan wraps from the reset ptr of 4 back to channel 0
    b_mode = 1'b1; b_mask = 5'b10011;
    #1;
    chk("n5_scan_ready0", 32'(b_ready), 32'h01);
    tick();
    chk("n5_scan_sel0", 32'(b_osel), 32'd0);
    tick();
    chk("n5_scan_sel1", 32'(b_osel), 32'd1);
    tick();
    chk("n5_scan_sel2", 32'(b_osel), 32'd4);
    chk("n5_scan_data2", 32'(b_odata), 32'h54);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux_nto1_scan.md
# mux_nto1_scan

Parametrised N-channel, W-bit registered multiplexer with a valid/ready handshake on every input and on the output. It is the successor to the fixed 16:1 single-bit combinational mux. It adds:
- per-channel data width;
- a manual-select mode and a round-robin auto-scan mode over a channel mask;
- one registered output stage with backpressure.

It sits between the per-channel sample sources and the single shared downstream consumer.

## Interface
- N_CH, 16, number of input channels (≥2)
- DATA_W, 8, bits per channel
- SEL_W, $clog2(N_CH), derived localparam, not overridable
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_data  in  N_CH*DATA_W  channel c occupies bits [c*DATA_W +: DATA_W]
- in_valid  in  N_CH  per-channel valid
- in_ready  out  N_CH  per-channel ready (one-hot or zero)
- mode  in  1  0 = MANUAL, 1 = SCAN
- sel  in  SEL_W  channel index used in MANUAL
- ch_mask  in  N_CH  channels eligible in SCAN (ignored in MANUAL)
- out_data  out  DATA_W  registered selected data
- out_sel  out  SEL_W  channel index of the beat in out_data
- out_valid  out  1  output register holds a beat
- out_ready  in  1  downstream accepts

## Operation
- load = !out_valid || out_ready; a capture happens only when load is 1 and a grant exists.
- MANUAL grant: channel sel, if sel < N_CH and in_valid[sel] = 1. If sel ≥ N_CH (non-power-of-two N_CH), there is no grant.
- SCAN grant: first channel c with in_valid[c] & ch_mask[c] = 1, searching upward from ptr+1 modulo N_CH (wrap-around).
- On a capture:
  - in_ready[grant] = 1 and all other in_ready = 0;
  - out_data ← selected data, out_sel ← grant, out_valid ← 1;
  - in SCAN only, ptr ← grant.
- in_ready is combinational from in_valid, mode, sel, ch_mask, ptr and out_ready. No other input-to-output combinational path exists.
- No capture while out_valid && !out_ready: all in_ready = 0, and out_data/out_sel are held stable.
- No capture and out_ready = 1: out_valid ← 0. out_data/out_sel keep their last value.
- FSM, two states:
  - EMPTY (out_valid = 0) → FULL on capture.
  - FULL → EMPTY on out_ready without capture.
  - FULL → FULL on out_ready with capture (back-to-back) or on stall.
- A mode, sel or ch_mask change affects only the next grant decision, never a beat already registered. ptr is retained across MANUAL periods.
- ch_mask = 0 in SCAN, or no valid channel: no grant, ptr unchanged.

## Timing
- Reset values (async assert, sync release on rst_n rising): out_valid = 0, out_data = 0, out_sel = 0, ptr = N_CH-1 (the first SCAN search starts at channel 0). in_ready = 0 because load needs a grant.
- Latency: input handshake at edge k → out_valid/out_data visible after edge k; the beat is accepted downstream at the first edge with out_ready = 1.
- Throughput: one beat per cycle while out_ready = 1.
- Reset asserted mid-transfer: the registered beat is dropped, and out_valid falls immediately (asynchronously).

## Structure
- Package mux_pkg:
  - mode_e {MODE_MANUAL = 0, MODE_SCAN = 1};
  - state_e {ST_EMPTY, ST_FULL};
  - shared localparam function for SEL_W.
- Sub-module rr_arbiter (N parameter): inputs req and ptr; outputs grant_vld and grant_idx. It is purely combinational rotate-priority logic and is reused by other scan blocks.
- Top module holds the output register, the ptr register, the FSM and the mode mux. Target 150–300 lines.

## Test plan
- MANUAL, sel = 5, in_valid = 16'h0020, data5 = 8'hA5, out_ready = 1 → in_ready = 16'h0020 for one cycle; the next cycle out_valid = 1, out_data = A5, out_sel = 5.
- SCAN, ch_mask = 16'hFFFF, all in_valid = 1, out_ready = 1, held 18 cycles after reset → out_sel sequence 0,1,…,15,0,1 (wrap).
- SCAN, ch_mask = 16'h8001, in_valid = 16'hFFFF → out_sel alternates 0,15,0,15; channels 1–14 never get in_ready.
- Backpressure: a beat with out_sel = 3 registered, out_ready = 0 for 4 cycles → out_data/out_sel constant and all in_ready = 0. With out_ready = 1, the next beat loads in the same cycle (out_valid stays 1).
- N_CH = 5, MANUAL, sel = 7 with in_valid = 5'h1F → no in_ready, out_valid remains 0.
- rst_n pulsed low while out_valid = 1 → out_valid = 0 asynchronously. After release, the first SCAN grant is channel 0.
